instr_prefetch: RTL and testbench

- Instruction fetch stage between the combinational-read Memory and the CPU core.
- Owns the program counter and drives the memory address bus.
- Captures each returned byte into a small prefetch FIFO and hands bytes to the CPU over a valid/ready handshake.
- Supports a jump/flush request from the CPU that redirects fetch to a new address.

---
 rtl/instr_prefetch_pkg.sv | 11 +
 rtl/prefetch_fifo.sv | 55 +++++
 rtl/instr_prefetch.sv | 55 +++++
 tb/tb_instr_prefetch.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared constants for the fetch path: default bus widths, reset PC and the
// width of the prefetch occupancy counter.
package instr_prefetch_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 8;
  localparam int RESET_PC_DEF = 0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// Pointer/count based synchronous FIFO with flush. The caller never pushes
// when full or pops when empty; flush wins over both.
module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr;
  logic [PTR_W-1:0]  rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + PTR_W'(1);
      if (pop)  rd <= rd + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; stale entries are unreachable while count==0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= din;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd];
endmodule

// File: rtl/instr_prefetch.sv
// Fetch stage: owns the PC, reads the combinational memory every cycle and
// queues returned bytes for the CPU; jump flushes and redirects fetch.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        mem_val,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     jump,
  input  logic [ADDR_W-1:0]        jump_addr,
  output logic [cnt_w(DEPTH)-1:0]  count
);
  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  // Jump suppresses both sides so a same-edge handshake is dropped.
  assign push        = !jump && !full;
  assign pop         = !jump && !empty && instr_ready;
  assign instr_valid = !empty;
  assign mem_addr    = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pc <= ADDR_W'(RESET_PC);
    else if (jump)  pc <= jump_addr;
    else if (push)  pc <= pc + ADDR_W'(1);
  end

  prefetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump),
    .din   (mem_val),
    .dout  (instr),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: queue-based scoreboard of expected fetch bytes
// plus directed checks around fill, wrap, jump and asynchronous reset.
module tb_instr_prefetch;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_val;
  logic [7:0] mem_addr;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       jump;
  logic [7:0] jump_addr;
  logic [2:0] count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [7:0] m_pc;

  always #5 clk = ~clk;

  // Memory image: mem[i] = i + 0x10
  assign mem_val = mem_addr + 8'h10;

  instr_prefetch #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_val     (mem_val),
    .mem_addr    (mem_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .count       (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the scoreboard, advance the model for the
  // coming edge, then move to 1 time unit after that edge.
  task automatic step();
    bit full_m;
    check("sb_cnt",   32'(count), 32'(q.size()));
    check("sb_vld",   32'(instr_valid), 32'(q.size() != 0));
    check("sb_addr",  32'(mem_addr), 32'(m_pc));
    check("sb_instr", 32'(instr), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    if (jump) begin
      q.delete();
      m_pc = jump_addr;
    end else begin
      full_m = (q.size() == DEPTH);
      if (instr_ready && q.size() != 0) void'(q.pop_front());
      if (!full_m) begin
        q.push_back(m_pc + 8'h10);
        m_pc = m_pc + 8'h01;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; instr_ready = 1'b0; jump = 1'b0; jump_addr = 8'h00;
    m_pc = 8'h00;
    #2;
    check("rst_addr",  32'(mem_addr), 32'h00);
    check("rst_vld",   32'(instr_valid), 32'h0);
    check("rst_cnt",   32'(count), 32'h0);
    check("rst_instr", 32'(instr), 32'h00);
    #10;
    rst = 1'b1;

    // First fetch: one edge to the first byte
    step();
    check("t1_vld",   32'(instr_valid), 32'h1);
    check("t1_instr", 32'(instr), 32'h10);
    check("t1_addr",  32'(mem_addr), 32'h01);

    // Fill until full; pc stalls
    repeat (5) step();
    check("t2_cnt",   32'(count), 32'h4);
    check("t2_addr",  32'(mem_addr), 32'h04);
    check("t2_instr", 32'(instr), 32'h10);

    // Pop at full frees a slot; push resumes on the next edge
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t3_cnt",   32'(count), 32'h3);
    check("t3_instr", 32'(instr), 32'h11);
    check("t3_addr",  32'(mem_addr), 32'h04);
    step();
    check("t3_cnt2",  32'(count), 32'h4);
    check("t3_addr2", 32'(mem_addr), 32'h05);

    // Streaming across the address wrap
    jump = 1'b1; jump_addr = 8'hFE; instr_ready = 1'b1;
    step();
    jump = 1'b0;
    check("t4_cnt0",  32'(count), 32'h0);
    check("t4_addr0", 32'(mem_addr), 32'hFE);
    step();
    check("t4_i0", 32'(instr), 32'h0E);
    check("t4_a0", 32'(mem_addr), 32'hFF);
    step();
    check("t4_i1", 32'(instr), 32'h0F);
    check("t4_a1", 32'(mem_addr), 32'h00);
    check("t4_c1", 32'(count), 32'h1);
    step();
    check("t4_i2", 32'(instr), 32'h10);
    check("t4_a2", 32'(mem_addr), 32'h01);
    check("t4_c2", 32'(count), 32'h1);

    // Jump with a simultaneous handshake at count=3
    instr_ready = 1'b0;
    repeat (2) step();
    check("t5_cnt3", 32'(count), 32'h3);
    jump = 1'b1; jump_addr = 8'h80; instr_ready = 1'b1;
    step();
    jump = 1'b0; instr_ready = 1'b0;
    check("t5_cnt", 32'(count), 32'h0);
    check("t5_vld", 32'(instr_valid), 32'h0);
    check("t5_addr", 32'(mem_addr), 32'h80);
    step();
    check("t5_instr", 32'(instr), 32'h90);
    check("t5_vld2", 32'(instr_valid), 32'h1);

    // Asynchronous reset between edges at count=2
    step();
    check("t6_cnt2", 32'(count), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_vld",   32'(instr_valid), 32'h0);
    check("t6_cnt",   32'(count), 32'h0);
    check("t6_addr",  32'(mem_addr), 32'h00);
    check("t6_instr", 32'(instr), 32'h00);
    q.delete();
    m_pc = 8'h00;
    #1;
    rst = 1'b1;

    // Random ready / occasional jump traffic against the scoreboard
    for (int i = 0; i < 60; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      jump        = ($urandom_range(0, 9) == 0);
      jump_addr   = 8'($urandom_range(0, 255));
      step();
    end
    jump = 1'b0;
    instr_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
